// File: rtl/spi_frame_scheduler.sv
// Streams one frame from the pixel BRAM to the SPI sender, one triggered byte per CS transaction.
// Optional CS handshake watchdog: define SPI_SCHED_WATCHDOG_EN.
module spi_frame_scheduler #(
   parameter int H_PIXELS       = 320,
   parameter int V_PIXELS       = 180,
   parameter int ADDR_WIDTH     = $clog2(H_PIXELS*V_PIXELS),
   parameter int BRAM_LATENCY   = 2,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  frame_start_in,
   output logic [ADDR_WIDTH-1:0] pixel_addr_out,
   input  logic [7:0]            pixel_data_in,
   output logic                  spi_trigger_out,
   output logic [7:0]            spi_data_out,
   input  logic                  spi_cs_in,
   output logic                  busy_out,
   output logic                  frame_done_out,
   output logic                  overrun_out,
   output logic                  timeout_out
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] FETCH     = 3'd1;
   localparam logic [2:0] SEND      = 3'd2;
   localparam logic [2:0] WAIT_LOW  = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;
   localparam logic [2:0] GAP       = 3'd5;

   localparam int CNT_MAX = (BRAM_LATENCY > GAP_CYCLES) ? BRAM_LATENCY : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]      LAT_LAST  = CNT_W'(BRAM_LATENCY - 1);
   localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_PIXELS*V_PIXELS - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             pixel_done;
   logic             watchdog_abort;

   assign busy_out = (state != IDLE);

   // Current pixel's transaction and inter-byte gap are complete; with no gap this is the CS rise.
   assign pixel_done = ((state == WAIT_HIGH) && spi_cs_in && (GAP_CYCLES == 0)) ||
                       ((state == GAP) && (cnt == GAP_LAST));

`ifdef SPI_SCHED_WATCHDOG_EN
   localparam int WD_MAX = (TIMEOUT_CYCLES > 4) ? TIMEOUT_CYCLES : 4;
   localparam int WD_W   = $clog2(WD_MAX + 1);
   localparam logic [WD_W-1:0] WD_LOW_LAST  = WD_W'(3);
   localparam logic [WD_W-1:0] WD_HIGH_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] wd_cnt;

   assign watchdog_abort = ((state == WAIT_LOW)  &&  spi_cs_in && (wd_cnt == WD_LOW_LAST)) ||
                           ((state == WAIT_HIGH) && !spi_cs_in && (wd_cnt == WD_HIGH_LAST));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wd_cnt      <= '0;
         timeout_out <= 1'b0;
      end else begin
         timeout_out <= watchdog_abort;
         // Re-armed on entry to each wait state so each phase gets its own budget.
         if ((state == SEND) || ((state == WAIT_LOW) && !spi_cs_in))
            wd_cnt <= '0;
         else if ((state == WAIT_LOW) || (state == WAIT_HIGH))
            wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign watchdog_abort = 1'b0;
   assign timeout_out    = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state           <= IDLE;
         cnt             <= '0;
         pixel_addr_out  <= '0;
         spi_trigger_out <= 1'b0;
         spi_data_out    <= '0;
         frame_done_out  <= 1'b0;
         overrun_out     <= 1'b0;
      end else begin
         spi_trigger_out <= 1'b0;
         frame_done_out  <= 1'b0;
         overrun_out     <= frame_start_in && (state != IDLE);

         case (state)
            IDLE: begin
               if (frame_start_in) begin
                  pixel_addr_out <= '0;
                  cnt            <= '0;
                  state          <= FETCH;
               end
            end
            FETCH: begin
               if (cnt == LAT_LAST) begin
                  spi_data_out    <= pixel_data_in;
                  spi_trigger_out <= 1'b1;
                  state           <= SEND;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SEND:     state <= WAIT_LOW;
            WAIT_LOW: if (!spi_cs_in) state <= WAIT_HIGH;
            WAIT_HIGH: begin
               if (spi_cs_in && (GAP_CYCLES != 0)) begin
                  cnt   <= '0;
                  state <= GAP;
               end
            end
            GAP:      cnt <= cnt + 1'b1;
            default:  state <= IDLE;
         endcase

         // NOTE: the last non-blocking assignment in the block wins, so these override the case arms.
         if (pixel_done) begin
            cnt <= '0;
            if (pixel_addr_out == LAST_ADDR) begin
               frame_done_out <= 1'b1;
               state          <= IDLE;
            end else begin
               pixel_addr_out <= pixel_addr_out + 1'b1;
               state          <= FETCH;
            end
         end

         if (watchdog_abort) begin
            pixel_addr_out <= '0;
            state          <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed bench: a 2x2 frame through two instances (GAP_CYCLES=4 and GAP_CYCLES=0),
// each with a one-register BRAM read model and a chip-select sender model.
module tb_spi_frame_scheduler;

   localparam int AW = 2;

   typedef struct {
      logic [7:0] mem_byte;
      int         off_gap4;
      int         off_gap0;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic          frame_start [2];
   logic [AW-1:0] pixel_addr  [2];
   logic [7:0]    pixel_data  [2];
   logic          trig        [2];
   logic [7:0]    sdata       [2];
   logic          cs          [2];
   logic          busy        [2];
   logic          done        [2];
   logic          ovr         [2];
   logic          tmo         [2];
   logic          cs_stuck    [2];
   int            cs_cnt      [2];

   vec_t       vec [4];
   logic [7:0] mem [4];

   spi_frame_scheduler #(
      .H_PIXELS(2), .V_PIXELS(2), .BRAM_LATENCY(2), .GAP_CYCLES(4)
   ) dut_gap4 (
      .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start[0]),
      .pixel_addr_out(pixel_addr[0]), .pixel_data_in(pixel_data[0]),
      .spi_trigger_out(trig[0]), .spi_data_out(sdata[0]), .spi_cs_in(cs[0]),
      .busy_out(busy[0]), .frame_done_out(done[0]), .overrun_out(ovr[0]),
      .timeout_out(tmo[0])
   );

   spi_frame_scheduler #(
      .H_PIXELS(2), .V_PIXELS(2), .BRAM_LATENCY(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)
   ) dut_gap0 (
      .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start[1]),
      .pixel_addr_out(pixel_addr[1]), .pixel_data_in(pixel_data[1]),
      .spi_trigger_out(trig[1]), .spi_data_out(sdata[1]), .spi_cs_in(cs[1]),
      .busy_out(busy[1]), .frame_done_out(done[1]), .overrun_out(ovr[1]),
      .timeout_out(tmo[1])
   );

   // BRAM: address registered in the DUT plus one read register here gives a latency of 2.
   always @(posedge clk)
      for (int g = 0; g < 2; g++) pixel_data[g] <= mem[pixel_addr[g]];

   // Sender: CS falls the cycle after a trigger, stays low 20 (gap4) or 8 (gap0) cycles.
   always @(posedge clk or negedge rst_n) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst_n) begin
            cs[g]     <= 1'b1;
            cs_cnt[g] <= 0;
         end else if (trig[g]) begin
            cs[g]     <= 1'b0;
            cs_cnt[g] <= (g == 0) ? 19 : 7;
         end else if (!cs[g] && !cs_stuck[g]) begin
            if (cs_cnt[g] == 0) cs[g] <= 1'b1;
            else cs_cnt[g] <= cs_cnt[g] - 1;
         end
      end
   end

   int            n_trig    [2];
   int            trig_at   [2][8];
   logic [7:0]    trig_val  [2][8];
   logic [AW-1:0] trig_addr [2][8];
   int            n_done    [2];
   int            done_at   [2][4];
   int            n_ovr     [2];
   int            ovr_at    [2][4];
   int            n_tmo     [2];
   int            wide_trig [2];
   logic          trig_prev [2];

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (trig[g]) begin
            if (trig_prev[g]) wide_trig[g]++;
            if (n_trig[g] < 8) begin
               trig_at[g][n_trig[g]]   = cyc;
               trig_val[g][n_trig[g]]  = sdata[g];
               trig_addr[g][n_trig[g]] = pixel_addr[g];
            end
            n_trig[g]++;
         end
         trig_prev[g] = trig[g];
         if (done[g]) begin
            if (n_done[g] < 4) done_at[g][n_done[g]] = cyc;
            n_done[g]++;
         end
         if (ovr[g]) begin
            if (n_ovr[g] < 4) ovr_at[g][n_ovr[g]] = cyc;
            n_ovr[g]++;
         end
         if (tmo[g]) n_tmo[g]++;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   task automatic clear_log();
      for (int g = 0; g < 2; g++) begin
         n_trig[g] = 0; n_done[g] = 0; n_ovr[g] = 0; n_tmo[g] = 0;
         wide_trig[g] = 0; trig_prev[g] = 1'b0;
         for (int i = 0; i < 8; i++) begin
            trig_at[g][i] = 0; trig_val[g][i] = '0; trig_addr[g][i] = '0;
         end
         for (int i = 0; i < 4; i++) begin
            done_at[g][i] = 0; ovr_at[g][i] = 0;
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic start_frame(input int g);
      frame_start[g] = 1'b1;
      @(negedge clk);
      frame_start[g] = 1'b0;
   endtask

   task automatic verify_frame(input int g, input int first, input int base, input string tag);
      for (int i = 0; i < 4; i++) begin
         int off;
         off = (g == 0) ? vec[i].off_gap4 : vec[i].off_gap0;
         check($sformatf("%s trig%0d cycle", tag, i), trig_at[g][first+i] - base, off);
         check($sformatf("%s trig%0d data", tag, i), trig_val[g][first+i], vec[i].mem_byte);
         check($sformatf("%s trig%0d addr", tag, i), trig_addr[g][first+i], i);
      end
   endtask

   int n;
   int n2;

   initial begin
      // Byte per address, then trigger cycle offset from the accepted start for each instance.
      vec[0] = '{8'hA5,  3,  3};
      vec[1] = '{8'h3C, 31, 15};
      vec[2] = '{8'h0F, 59, 27};
      vec[3] = '{8'hF0, 87, 39};
      for (int i = 0; i < 4; i++) mem[i] = vec[i].mem_byte;

      rst_n       = 1'b0;
      frame_start = '{1'b0, 1'b0};
      cs_stuck    = '{1'b0, 1'b0};
      clear_log();
      repeat (3) @(negedge clk);

      for (int g = 0; g < 2; g++) begin
         check($sformatf("rst%0d addr", g), pixel_addr[g], 0);
         check($sformatf("rst%0d trigger", g), trig[g], 0);
         check($sformatf("rst%0d data", g), sdata[g], 0);
         check($sformatf("rst%0d busy", g), busy[g], 0);
         check($sformatf("rst%0d done", g), done[g], 0);
         check($sformatf("rst%0d overrun", g), ovr[g], 0);
         check($sformatf("rst%0d timeout", g), tmo[g], 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Frame 1, then frame 2 started in the frame_done cycle with an overrun 10 cycles in.
      n = cyc;
      start_frame(0);
      check("f1 addr at N+1", pixel_addr[0], 0);
      check("f1 busy at N+1", busy[0], 1);
      wait_until(n + 113);
      check("f1 done cycle", done[0], 1);
      check("f1 busy in done cycle", busy[0], 0);
      n2 = cyc;
      start_frame(0);
      wait_until(n2 + 10);
      start_frame(0);
      wait_until(n2 + 125);
      check("f1+f2 trigger count", n_trig[0], 8);
      verify_frame(0, 0, n, "f1");
      verify_frame(0, 4, n2, "f2");
      check("f1+f2 done count", n_done[0], 2);
      check("f1 done offset", done_at[0][0] - n, 113);
      check("f2 done offset", done_at[0][1] - n2, 113);
      check("overrun count", n_ovr[0], 1);
      check("overrun offset", ovr_at[0][0] - n2, 11);
      check("gap4 trigger width", wide_trig[0], 0);
      check("gap4 timeout count", n_tmo[0], 0);

      // Zero gap: the next address follows the CS rise by one cycle.
      clear_log();
      n = cyc;
      start_frame(1);
      wait_until(n + 12);
      check("gap0 addr at CS rise", pixel_addr[1], 0);
      wait_until(n + 13);
      check("gap0 addr after CS rise", pixel_addr[1], 1);
      wait_until(n + 60);
      check("gap0 trigger count", n_trig[1], 4);
      verify_frame(1, 0, n, "gap0");
      check("gap0 done count", n_done[1], 1);
      check("gap0 done offset", done_at[1][0] - n, 49);
      check("gap0 overrun count", n_ovr[1], 0);
      check("gap0 trigger width", wide_trig[1], 0);

      // Asynchronous reset while pixel 2 waits for CS to rise.
      clear_log();
      n = cyc;
      start_frame(0);
      wait_until(n + 40);
      check("pre-reset busy", busy[0], 1);
      check("pre-reset addr", pixel_addr[0], 1);
      check("pre-reset data", sdata[0], 8'h3C);
      #2 rst_n = 1'b0;
      #1;
      check("async rst addr", pixel_addr[0], 0);
      check("async rst trigger", trig[0], 0);
      check("async rst data", sdata[0], 0);
      check("async rst busy", busy[0], 0);
      check("async rst done", done[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check("post-reset trigger count", n_trig[0], 2);
      check("post-reset busy", busy[0], 0);
      check("post-reset done count", n_done[0], 0);

      // Sender never releases CS.
      clear_log();
      cs_stuck[1] = 1'b1;
      n = cyc;
      start_frame(1);
`ifdef SPI_SCHED_WATCHDOG_EN
      wait_until(n + 20);
      check("wd busy in 16th wait cycle", busy[1], 1);
      check("wd timeout before abort", tmo[1], 0);
      wait_until(n + 21);
      check("wd timeout pulse", tmo[1], 1);
      check("wd busy after abort", busy[1], 0);
      check("wd addr after abort", pixel_addr[1], 0);
      wait_until(n + 40);
      check("wd timeout count", n_tmo[1], 1);
      check("wd done count", n_done[1], 0);
      check("wd trigger count", n_trig[1], 1);
`else
      wait_until(n + 60);
      check("stuck cs busy held", busy[1], 1);
      check("stuck cs timeout low", tmo[1], 0);
      check("stuck cs timeout count", n_tmo[1], 0);
      check("stuck cs trigger count", n_trig[1], 1);
`endif
      cs_stuck[1] = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
